// File: rtl/data_sram_responder_pkg.sv
// Shared types and widths for the data-SRAM responder.
// Holds bus widths, size encodings and the response-queue entry layout.
// No logic; imported by the interface, the response queue and the top.
package data_sram_responder_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  // Countdown field is wide enough for latencies up to 15.
  localparam int CD_W   = 4;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef struct packed {
    logic              is_write;
    logic [DATA_W-1:0] rdata;
    logic [CD_W-1:0]   countdown;
  } resp_entry_t;

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bus between the EX/MEM requester and the responder.
// Pure wiring, no latency of its own.
// Requester waits on addr_ok; data_ok has no backpressure.
interface data_sram_responder_if;
  import data_sram_responder_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue; each entry counts down from LATENCY-1 after push.
// Head is ready the cycle its countdown reaches zero; pop is same-cycle.
// No internal backpressure: caller must not push when count == DEPTH.
module data_sram_responder_resp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       push_is_write,
  input  logic [DATA_W-1:0]          push_rdata,
  input  logic                       pop,
  output logic                       head_ready,
  output resp_entry_t                head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  resp_entry_t         entries [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_q;

  // Pointers wrap at DEPTH, which need not fill the pointer width.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Load new entries, age every entry toward zero, advance pointers and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == PTR_W'(i)) begin
          entries[i].is_write  <= push_is_write;
          entries[i].rdata     <= push_rdata;
          entries[i].countdown <= CD_W'(LATENCY - 1);
        end else if (entries[i].countdown != '0) begin
          entries[i].countdown <= entries[i].countdown - CD_W'(1);
        end
      end
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head       = entries[rd_ptr];
  assign head_ready = (count_q != '0) && (head.countdown == '0);
  assign count      = count_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM slave: word memory with byte-strobe writes and in-order responses.
// Accept at edge E gives a one-cycle data_ok in the cycle after edge E+RESP_LATENCY-1.
// addr_ok drops while MAX_OUTSTANDING responses are pending; data_ok cannot be stalled.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = 12,
  parameter int RESP_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  data_sram_responder_if.slave               data_sram,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int MEM_DEPTH = 1 << ADDR_WORDS_LOG2;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING) + 1;

  logic [DATA_W-1:0]          mem [MEM_DEPTH];
  logic [ADDR_WORDS_LOG2-1:0] index;
  logic [DATA_W-1:0]          rd_word;
  logic                       addr_ok;
  logic                       accept;
  logic                       head_ready;
  resp_entry_t                head;

  // Size and out-of-range address bits carry no meaning here: strobes rule
  // and the address simply wraps modulo the memory depth.
  logic unused_bits;
  assign unused_bits = ^{data_sram.size, data_sram.addr[1:0],
                         data_sram.addr[ADDR_W-1:ADDR_WORDS_LOG2+2]};

  assign index   = data_sram.addr[ADDR_WORDS_LOG2+1:2];
  assign addr_ok = ~reset & (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign accept  = data_sram.req & addr_ok;
  assign rd_word = mem[index];

  // Byte-merge accepted writes; memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram.wstrb[b]) mem[index][8*b +: 8] <= data_sram.wdata[8*b +: 8];
      end
    end
  end

  // Reads capture the pre-edge word, so a read after a write sees the new data.
  data_sram_responder_resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .LATENCY (RESP_LATENCY)
  ) u_resp_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (accept),
    .push_is_write (data_sram.wr),
    .push_rdata    (data_sram.wr ? '0 : rd_word),
    .pop           (head_ready),
    .head_ready    (head_ready),
    .head          (head),
    .count         (outstanding)
  );

  assign data_sram.addr_ok = addr_ok;
  assign data_sram.data_ok = head_ready;
  assign data_sram.rdata   = (head_ready && !head.is_write) ? head.rdata : '0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (latency 2, 1 and 8).
// Stimulus pushes hand-computed responses; a negedge monitor checks order, data and cycle.
// Requests wait on addr_ok with a bounded timeout.
module tb_data_sram_responder;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{2, 1, 8};

  typedef struct {
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_d   [NDUT];
  logic        req_d   [NDUT];
  logic        wr_d    [NDUT];
  logic [3:0]  strb_d  [NDUT];
  logic [31:0] addr_d  [NDUT];
  logic [31:0] wdata_d [NDUT];
  logic        aok_m   [NDUT];
  logic        dok_m   [NDUT];
  logic [31:0] rd_m    [NDUT];
  logic [2:0]  out_m   [NDUT];

  data_sram_responder_if if0 ();
  data_sram_responder_if if1 ();
  data_sram_responder_if if2 ();

  assign if0.req = req_d[0];  assign if0.wr = wr_d[0];  assign if0.size = 2'd2;
  assign if0.wstrb = strb_d[0];  assign if0.addr = addr_d[0];  assign if0.wdata = wdata_d[0];
  assign aok_m[0] = if0.addr_ok;  assign dok_m[0] = if0.data_ok;  assign rd_m[0] = if0.rdata;

  assign if1.req = req_d[1];  assign if1.wr = wr_d[1];  assign if1.size = 2'd2;
  assign if1.wstrb = strb_d[1];  assign if1.addr = addr_d[1];  assign if1.wdata = wdata_d[1];
  assign aok_m[1] = if1.addr_ok;  assign dok_m[1] = if1.data_ok;  assign rd_m[1] = if1.rdata;

  assign if2.req = req_d[2];  assign if2.wr = wr_d[2];  assign if2.size = 2'd2;
  assign if2.wstrb = strb_d[2];  assign if2.addr = addr_d[2];  assign if2.wdata = wdata_d[2];
  assign aok_m[2] = if2.addr_ok;  assign dok_m[2] = if2.data_ok;  assign rd_m[2] = if2.rdata;

  data_sram_responder #(.ADDR_WORDS_LOG2(12), .RESP_LATENCY(2), .MAX_OUTSTANDING(4)) u0 (
    .clk(clk), .reset(rst_d[0]), .data_sram(if0), .outstanding(out_m[0]));
  data_sram_responder #(.ADDR_WORDS_LOG2(12), .RESP_LATENCY(1), .MAX_OUTSTANDING(4)) u1 (
    .clk(clk), .reset(rst_d[1]), .data_sram(if1), .outstanding(out_m[1]));
  data_sram_responder #(.ADDR_WORDS_LOG2(12), .RESP_LATENCY(8), .MAX_OUTSTANDING(4)) u2 (
    .clk(clk), .reset(rst_d[2]), .data_sram(if2), .outstanding(out_m[2]));

  exp_t sb [NDUT][$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: every data_ok must match the oldest expectation, on its due cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (dok_m[k]) begin
        checks++;
        if (sb[k].size() == 0) begin
          failures++;
          $display("FAIL unexpected_data_ok dut%0d cyc=%0d got rdata=%h, none expected", k, cyc, rd_m[k]);
        end else begin
          mon_e = sb[k].pop_front();
          if (rd_m[k] !== mon_e.rdata || cyc != mon_e.due) begin
            failures++;
            $display("FAIL response dut%0d got rdata=%h cyc=%0d, want rdata=%h cyc=%0d",
                     k, rd_m[k], cyc, mon_e.rdata, mon_e.due);
          end
        end
      end else if (sb[k].size() != 0 && sb[k][0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_data_ok dut%0d cyc=%0d, want rdata=%h at cyc=%0d",
                 k, cyc, sb[k][0].rdata, sb[k][0].due);
        void'(sb[k].pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge with req still high.
  task automatic issue(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, output int acc);
    int n;
    req_d[k] = 1'b1; wr_d[k] = w; strb_d[k] = s; addr_d[k] = a; wdata_d[k] = d;
    n = 0;
    @(negedge clk);
    while (!aok_m[k] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!aok_m[k]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d addr=%h got addr_ok=0 want 1", k, a);
      acc = -1;
    end else begin
      sb[k].push_back('{exp_rd, cyc + LAT[k]});
      acc = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Inputs are don't-care with req low; drive X to show it stays out of state.
  task automatic idle(input int k);
    req_d[k] = 1'b0; wr_d[k] = 1'bx; strb_d[k] = 4'bxxxx;
    addr_d[k] = 'x; wdata_d[k] = 'x;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((out_m[k] != 3'd0 || sb[k].size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (out_m[k] != 3'd0 || sb[k].size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout dut%0d got outstanding=%0d pending=%0d want 0",
               k, out_m[k], sb[k].size());
    end
  endtask

  int a1, a5, dummy;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      rst_d[k] = 1'b1;
      idle(k);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset_outstanding%0d", k), 32'(out_m[k]), 32'd0);
      check($sformatf("reset_addr_ok%0d", k), 32'(aok_m[k]), 32'd0);
      check($sformatf("reset_data_ok%0d", k), 32'(dok_m[k]), 32'd0);
      check($sformatf("reset_rdata%0d", k), rd_m[k], 32'd0);
      rst_d[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < NDUT; k++) check($sformatf("post_reset_addr_ok%0d", k), 32'(aok_m[k]), 32'd1);
    @(posedge clk);
    #1;

    // Latency 2: write then read of the same word, then byte/half merges.
    issue(0, 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0,        dummy);
    issue(0, 1'b0, 4'b0000, 32'h100, 32'h0,        32'hDEADBEEF, dummy);
    issue(0, 1'b1, 4'b1111, 32'h200, 32'h11223344, 32'h0,        dummy);
    issue(0, 1'b1, 4'b0100, 32'h200, 32'hAAAAAAAA, 32'h0,        dummy);
    issue(0, 1'b0, 4'b0000, 32'h200, 32'h0,        32'h11AA3344, dummy);
    issue(0, 1'b1, 4'b1100, 32'h200, 32'hBBBBBBBB, 32'h0,        dummy);
    issue(0, 1'b0, 4'b0000, 32'h200, 32'h0,        32'hBBBB3344, dummy);
    issue(0, 1'b1, 4'b0000, 32'h200, 32'hFFFFFFFF, 32'h0,        dummy);
    issue(0, 1'b0, 4'b0000, 32'h200, 32'h0,        32'hBBBB3344, dummy);
    // Address wrap: 0x4000 aliases word 0 with 4096 words.
    issue(0, 1'b1, 4'b1111, 32'h4000, 32'h5A5A5A5A, 32'h0,       dummy);
    issue(0, 1'b0, 4'b0000, 32'h0,    32'h0,        32'h5A5A5A5A, dummy);
    idle(0);
    wait_idle(0);

    // Latency 1: preload three words, then back-to-back reads answer every cycle.
    issue(1, 1'b1, 4'b1111, 32'h0, 32'h01010101, 32'h0, dummy);
    issue(1, 1'b1, 4'b1111, 32'h4, 32'h02020202, 32'h0, dummy);
    issue(1, 1'b1, 4'b1111, 32'h8, 32'h03030303, 32'h0, dummy);
    issue(1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h01010101, dummy);
    issue(1, 1'b0, 4'b0000, 32'h4, 32'h0, 32'h02020202, dummy);
    issue(1, 1'b0, 4'b0000, 32'h8, 32'h0, 32'h03030303, dummy);
    idle(1);
    wait_idle(1);

    // Latency 8, depth 4: fill the queue with req held high and watch the throttle.
    issue(2, 1'b1, 4'b1111, 32'h40, 32'hCAFEF00D, 32'h0, dummy);
    idle(2);
    wait_idle(2);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, a1);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    check("full_outstanding", 32'(out_m[2]), 32'd4);
    check("full_addr_ok", 32'(aok_m[2]), 32'd0);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, a5);
    // First data_ok in cycle a1+7, pop at edge a1+8, addr_ok back after it, accept at a1+9.
    check("refill_accept_edge", 32'(a5 - a1), 32'd9);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    idle(2);
    wait_idle(2);

    // Reset with three pending responses: all discarded, memory kept.
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    check("pre_reset_outstanding", 32'(out_m[2]), 32'd3);
    idle(2);
    rst_d[2] = 1'b1;
    sb[2].delete();
    #1;
    check("midreset_outstanding", 32'(out_m[2]), 32'd0);
    check("midreset_addr_ok", 32'(aok_m[2]), 32'd0);
    check("midreset_data_ok", 32'(dok_m[2]), 32'd0);
    @(posedge clk);
    #1;
    check("midreset_outstanding_next", 32'(out_m[2]), 32'd0);
    rst_d[2] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    issue(2, 1'b0, 4'b0000, 32'h40, 32'h0, 32'hCAFEF00D, dummy);
    idle(2);
    wait_idle(2);

    for (int k = 0; k < NDUT; k++) wait_idle(k);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the core's data-SRAM request/response interface. The EX stage issues requests with req/wr/size/wstrb/addr/wdata and waits for addr_ok; this block answers them.
- Accepts requests, applies writes to an internal word-addressed memory, and returns one in-order data_ok/rdata response per accepted request after a fixed latency.
- Used as the data-side memory model in the SoC bench and as the reference responder for verifying the EX/MEM handshake.

Parameters:
- ADDR_WORDS_LOG2, 12, log2 of memory depth in 32-bit words.
- RESP_LATENCY, 2, minimum cycles from acceptance to data_ok (legal range 1..15).
- MAX_OUTSTANDING, 4, response FIFO depth (power of two, ≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1=write, 0=read.
- data_sram_size  in  2  0=byte, 1=half, 2=word.
- data_sram_wstrb  in  4  byte enables for writes.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data, already lane-replicated by the requester.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
- data_sram_data_ok  out  1  one-cycle response pulse.
- data_sram_rdata  out  32  full read word, valid with data_ok; 0 for write responses.
- outstanding  out  log2(MAX_OUTSTANDING)+1  number of accepted but unanswered requests.

Behaviour:
- Reset (async assert, sync release): addr_ok=0, data_ok=0, rdata=0, outstanding=0. FIFO pointers and per-entry countdowns clear. Memory contents are not reset.
- addr_ok is registered-free combinational: equals ~reset & (outstanding < MAX_OUTSTANDING). It does not depend on req.
- Accept = req & addr_ok at a rising edge.
- Index = addr[ADDR_WORDS_LOG2+1:2]. Higher address bits are ignored, so the address wraps modulo the memory depth.
- Write accept: for each byte i with wstrb[i]=1, mem[index] byte i <= wdata byte i in the same edge. size is not re-checked; wstrb is authoritative. Write with wstrb=0 changes nothing but still gets a response.
- Read accept: the word mem[index] is sampled at acceptance and stored in the FIFO entry. Ordering is therefore strict program order: a read accepted after a write to the same word returns the new data.
- Each FIFO entry holds {is_write, rdata, countdown}. countdown loads RESP_LATENCY-1 on accept and decrements each cycle, saturating at 0.
- data_ok=1 in a cycle iff FIFO is non-empty and head countdown==0. data_ok, rdata and pop all happen in that cycle.
- At most one response per cycle, always in order. No backpressure on data_ok; the requester must take it.
- Latency: accept at edge E gives data_ok in the cycle after edge E+RESP_LATENCY-1. With RESP_LATENCY=1, data_ok is high in the cycle immediately after acceptance.
- Back-to-back accepts give back-to-back responses.
- Simultaneous accept and pop: outstanding unchanged. Full FIFO with a pop in the same cycle: addr_ok stays 0 that cycle; new accepts resume next cycle.
- FIFO pointers wrap modulo MAX_OUTSTANDING. outstanding counts 0..MAX_OUTSTANDING inclusive.
- Reset mid-operation discards all pending responses immediately; no data_ok follows. Memory writes already accepted persist.
- Inputs are don't-care when req=0. X on an input while req=0 must not propagate into state.

Decomposition:
- Shared package holds: size encodings (SIZE_B=0, SIZE_H=1, SIZE_W=2), the FIFO entry struct/typedef, and bus widths (ADDR_W=32, DATA_W=32).
- One natural sub-module: resp_fifo, a parameterized in-order queue with per-entry countdown, push/pop/head_ready and count output.
- The memory array and write-merge logic stay in the top module.

Test Plan:
1. Basic write then read, LATENCY=2: st.w addr 0x100 wdata 0xDEADBEEF wstrb 1111, then read 0x100 on the next cycle → data_ok 2 cycles after each accept; second rdata=0xDEADBEEF, first rdata=0.
2. Byte merge: word 0x200 preset to 0x11223344; write wdata 0xAAAAAAAA wstrb 0100; read 0x200 → 0x11AA3344. Half write wstrb 1100 wdata 0xBBBBBBBB → 0xBBBB3344.
3. Fill and throttle, MAX_OUTSTANDING=4, req held high → 4 accepts, addr_ok drops with outstanding=4. The first data_ok re-enables addr_ok the following cycle; total responses equal total accepts, in order.
4. Latency 1, continuous reads of 0x0,0x4,0x8 → data_ok each cycle starting the cycle after the first accept, rdata matching preloaded words in order.
5. Address wrap, ADDR_WORDS_LOG2=12: write 0x5A5A5A5A to 0x00004000, read 0x00000000 → 0x5A5A5A5A.
6. Reset with 3 outstanding → next cycle outstanding=0, data_ok=0, addr_ok=0 during reset. After release no stale data_ok appears, and prior memory writes read back intact.
